mac_hash_lookup: RTL and testbench

Hashed exact-match MAC table that consumes the 32-bit one-at-a-time hash produced by the upstream pipelined hasher and returns hit/miss plus the egress port for each 48-bit key. It receives the key in the same cycle the hasher does, delays it internally to re-align with the hash, and indexes a direct-mapped table of {valid, key, port} entries. A learn write port and a sweep-based clear engine maintain the table.

---
 rtl/mac_hash_lookup.sv | 180 ++++++++++++++++++
 tb/tb_mac_hash_lookup.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_hash_lookup.sv
// Direct-mapped exact-match MAC table indexed by an externally computed hash.
// The key is delayed to meet its hash, then looked up through a 3-stage pipeline.
module mac_hash_lookup #(
    parameter int HASH_LAT   = 7,
    parameter int INDEX_BITS = 10,
    parameter int PORT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [47:0]           key,
    input  logic [31:0]           hash,
    output logic                  lkup_valid,
    output logic                  lkup_hit,
    output logic [PORT_WIDTH-1:0] lkup_port,
    output logic [47:0]           lkup_key,
    input  logic                  learn_valid,
    output logic                  learn_ready,
    input  logic [INDEX_BITS-1:0] learn_index,
    input  logic [47:0]           learn_key,
    input  logic [PORT_WIDTH-1:0] learn_port,
    input  logic                  clear_req,
    output logic                  clear_busy
);
    localparam int ENTRY_W = 1 + 48 + PORT_WIDTH;
    localparam int DEPTH   = 1 << INDEX_BITS;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                  state_reg;
    logic [INDEX_BITS-1:0]   sweep_reg;
    logic                    busy_reg;
    logic                    ready_reg;

    logic [HASH_LAT-1:0]       dly_valid_reg;
    logic [HASH_LAT-1:0][47:0] dly_key_reg;

    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [ENTRY_W-1:0]      ram_q_reg;

    logic                    we;
    logic [INDEX_BITS-1:0]   waddr;
    logic [ENTRY_W-1:0]      wdata;
    logic [INDEX_BITS-1:0]   rd_index;
    logic                    unused_hash_bits;

    logic                    a_valid_reg;
    logic                    a_clear_reg;
    logic                    a_byp_reg;
    logic [ENTRY_W-1:0]      a_byp_data_reg;
    logic [47:0]             a_key_reg;

    logic [ENTRY_W-1:0]      entry;
    logic                    entry_hit;

    logic                    b_valid_reg;
    logic                    b_hit_reg;
    logic [PORT_WIDTH-1:0]   b_port_reg;
    logic [47:0]             b_key_reg;

    assign rd_index         = hash[INDEX_BITS-1:0];
    assign unused_hash_bits = ^hash[31:INDEX_BITS];
    assign learn_ready      = ready_reg & ~reset;
    assign clear_busy       = busy_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= CLEAR;
            sweep_reg <= '0;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (clear_req) begin
                        sweep_reg <= '0;
                    end else begin
                        sweep_reg <= sweep_reg + 1'b1;
                        if (sweep_reg == INDEX_BITS'(DEPTH - 1)) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state_reg <= CLEAR;
                        sweep_reg <= '0;
                        busy_reg  <= 1'b1;
                        ready_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= CLEAR;
                    sweep_reg <= '0;
                end
            endcase
        end
    end

    // Single write port: the sweep owns it while clearing, learns otherwise.
    always_comb begin
        we    = 1'b0;
        waddr = learn_index;
        wdata = {1'b1, learn_key, learn_port};
        if (state_reg == CLEAR) begin
            we    = 1'b1;
            waddr = sweep_reg;
            wdata = '0;
        end else if (learn_valid && learn_ready) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        ram_q_reg <= mem[rd_index];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_valid_reg <= '0;
        end else begin
            dly_valid_reg <= {dly_valid_reg[HASH_LAT-2:0], key_valid};
        end
        dly_key_reg <= {dly_key_reg[HASH_LAT-2:0], key};
    end

    // Stage A: the aligned key meets its hash; capture any same-cycle write
    // to the read index so the lookup sees it regardless of RAM read mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_reg <= 1'b0;
        end else begin
            a_valid_reg <= dly_valid_reg[HASH_LAT-1];
        end
        a_key_reg      <= dly_key_reg[HASH_LAT-1];
        a_clear_reg    <= (state_reg == CLEAR);
        a_byp_reg      <= we && (waddr == rd_index);
        a_byp_data_reg <= wdata;
    end

    assign entry     = a_byp_reg ? a_byp_data_reg : ram_q_reg;
    assign entry_hit = a_valid_reg && !a_clear_reg && entry[ENTRY_W-1]
                       && (entry[ENTRY_W-2 -: 48] == a_key_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            b_valid_reg <= 1'b0;
            b_hit_reg   <= 1'b0;
            b_port_reg  <= '0;
            b_key_reg   <= '0;
        end else begin
            b_valid_reg <= a_valid_reg;
            b_hit_reg   <= entry_hit;
            b_port_reg  <= entry_hit ? entry[PORT_WIDTH-1:0] : '0;
            b_key_reg   <= a_key_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lkup_valid <= 1'b0;
            lkup_hit   <= 1'b0;
            lkup_port  <= '0;
            lkup_key   <= '0;
        end else begin
            lkup_valid <= b_valid_reg;
            lkup_hit   <= b_valid_reg & b_hit_reg;
            lkup_port  <= b_valid_reg ? b_port_reg : '0;
            lkup_key   <= b_key_reg;
        end
    end
endmodule

// File: tb/tb_mac_hash_lookup.sv
// Scoreboard bench: a behavioural table model predicts each lookup at its
// hash-aligned cycle; results are popped and compared as lkup_valid arrives.
module tb_mac_hash_lookup;
    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [47:0] key;
    logic [31:0] hash;
    logic        lkup_valid;
    logic        lkup_hit;
    logic [7:0]  lkup_port;
    logic [47:0] lkup_key;
    logic        learn_valid;
    logic        learn_ready;
    logic [9:0]  learn_index;
    logic [47:0] learn_key;
    logic [7:0]  learn_port;
    logic        clear_req;
    logic        clear_busy;

    mac_hash_lookup dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key(key), .hash(hash),
        .lkup_valid(lkup_valid), .lkup_hit(lkup_hit), .lkup_port(lkup_port),
        .lkup_key(lkup_key), .learn_valid(learn_valid), .learn_ready(learn_ready),
        .learn_index(learn_index), .learn_key(learn_key), .learn_port(learn_port),
        .clear_req(clear_req), .clear_busy(clear_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [7:0]  port;
        logic [47:0] key;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_results = 0;
    int          cyc = 0;
    int          busy_left = 0;
    logic        mon_en = 1'b0;
    logic [31:0] req_hash;

    logic        rp_v [7];
    logic [47:0] rp_k [7];
    logic [31:0] hpipe [7];
    logic        tv [1024];
    logic [47:0] tk [1024];
    logic [7:0]  tp [1024];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] oat(input logic [47:0] k);
        logic [31:0] h;
        h = 32'h0;
        for (int b = 5; b >= 0; b--) begin
            h = h + {24'h0, k[b*8 +: 8]};
            h = h + (h << 10);
            h = h ^ (h >> 6);
        end
        h = h + (h << 3);
        h = h ^ (h >> 11);
        h = h + (h << 15);
        return h;
    endfunction

    task automatic wipe();
        for (int i = 0; i < 1024; i++) tv[i] = 1'b0;
    endtask

    // One clock: evaluate the model on the sampled inputs, then advance the
    // bench-side hasher pipeline that drives the hash input.
    task automatic step();
        logic        busy, fire, s_rst, s_kv;
        logic [47:0] s_key;
        logic [31:0] s_h;
        int          idx;
        exp_t        e;
        @(posedge clk);
        s_rst = reset; s_kv = key_valid; s_key = key; s_h = req_hash;
        busy = (busy_left != 0);
        fire = learn_valid && !s_rst && !busy;
        if (fire) begin
            tv[learn_index] = 1'b1;
            tk[learn_index] = learn_key;
            tp[learn_index] = learn_port;
        end
        if (rp_v[6] && !s_rst) begin
            idx = int'(hpipe[6][9:0]);
            e.hit  = !busy && tv[idx] && (tk[idx] == rp_k[6]);
            e.port = e.hit ? tp[idx] : 8'h0;
            e.key  = rp_k[6];
            e.due  = cyc + 3;
            sbq.push_back(e);
        end
        if (s_rst) begin
            sbq.delete();
            busy_left = 1024;
            wipe();
        end else if (busy) begin
            busy_left = clear_req ? 1024 : busy_left - 1;
        end else if (clear_req) begin
            busy_left = 1024;
            wipe();
        end
        cyc++;
        #1;
        for (int i = 6; i > 0; i--) begin
            rp_v[i]  = s_rst ? 1'b0 : rp_v[i-1];
            rp_k[i]  = rp_k[i-1];
            hpipe[i] = hpipe[i-1];
        end
        rp_v[0]  = s_kv && !s_rst;
        rp_k[0]  = s_key;
        hpipe[0] = s_h;
        hash     = hpipe[6];
    endtask

    task automatic lookup(input logic [47:0] k, input logic [31:0] h);
        key_valid = 1'b1; key = k; req_hash = h;
        step();
        key_valid = 1'b0;
    endtask

    task automatic learn(input logic [9:0] idx, input logic [47:0] k, input logic [7:0] p);
        learn_valid = 1'b1; learn_index = idx; learn_key = k; learn_port = p;
        step();
        learn_valid = 1'b0;
    endtask

    task automatic count_busy(input string tag, input int lkup_at);
        int n;
        n = 0;
        while (clear_busy && n < 1100) begin
            n++;
            if (n == lkup_at) begin
                key_valid = 1'b1; key = 48'h001122334455; req_hash = oat(48'h001122334455);
            end else begin
                key_valid = 1'b0;
            end
            step();
        end
        key_valid = 1'b0;
        check(tag, 64'(n), 64'd1024);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("clear_busy", 64'(clear_busy), 64'(busy_left != 0));
            check("learn_ready", 64'(learn_ready), 64'(!reset && busy_left == 0));
            if (lkup_valid) begin
                n_results++;
                if (sbq.size() == 0) begin
                    check("unexpected_lkup_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("lkup_hit", 64'(lkup_hit), 64'(mon_e.hit));
                    check("lkup_port", 64'(lkup_port), 64'(mon_e.port));
                    check("lkup_key", 64'(lkup_key), 64'(mon_e.key));
                    check("lkup_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end
        end
    end

    initial begin
        logic [31:0] h;
        logic [47:0] k;
        reset = 1'b1; key_valid = 1'b0; key = '0; hash = '0; req_hash = '0;
        learn_valid = 1'b0; learn_index = '0; learn_key = '0; learn_port = '0;
        clear_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rp_v[i] = 1'b0; rp_k[i] = '0; hpipe[i] = '0;
        end
        step();
        mon_en = 1'b1;
        check("rst_lkup_valid", 64'(lkup_valid), 64'd0);
        check("rst_lkup_hit", 64'(lkup_hit), 64'd0);
        check("rst_lkup_port", 64'(lkup_port), 64'd0);
        check("rst_lkup_key", 64'(lkup_key), 64'd0);
        check("rst_clear_busy", 64'(clear_busy), 64'd1);
        check("rst_learn_ready", 64'(learn_ready), 64'd0);
        step(); step();
        reset = 1'b0;
        count_busy("sweep_len", 500);
        repeat (12) step();

        // Learn then look up the same key.
        h = oat(48'h001122334455);
        learn(h[9:0], 48'h001122334455, 8'h04);
        lookup(48'h001122334455, h);
        repeat (12) step();

        // Different key forced onto an occupied index.
        h = oat(48'hAABBCCDDEEFF);
        learn(h[9:0], 48'hAABBCCDDEEFF, 8'h02);
        lookup(48'h0A0B0C0D0E0F, h);
        lookup(48'hAABBCCDDEEFF, h);
        repeat (12) step();

        // 64 back-to-back lookups, alternating learned / unlearned keys.
        for (int j = 0; j < 32; j++) begin
            k = 48'h020000000000 + 48'(j);
            h = oat(k);
            learn(h[9:0], k, 8'(j + 16));
        end
        for (int j = 0; j < 64; j++) begin
            k = (j % 2 == 0) ? 48'h020000000000 + 48'(j / 2) : 48'h030000000000 + 48'(j);
            key_valid = 1'b1; key = k; req_hash = oat(k);
            step();
        end
        key_valid = 1'b0;
        repeat (12) step();

        // Learn lands in the very cycle the lookup's hash-aligned read happens.
        h = oat(48'h0C0C0C0C0C0C);
        lookup(48'h0C0C0C0C0C0C, h);
        repeat (6) step();
        learn(h[9:0], 48'h0C0C0C0C0C0C, 8'h5A);
        repeat (12) step();

        // Ten entries, then clear with a coincident learn that must be erased.
        for (int j = 0; j < 10; j++) begin
            k = 48'h050000000000 + 48'(j);
            h = oat(k);
            learn(h[9:0], k, 8'(j + 1));
        end
        h = oat(48'h06060606060A);
        clear_req = 1'b1;
        learn_valid = 1'b1; learn_index = h[9:0]; learn_key = 48'h06060606060A; learn_port = 8'h77;
        step();
        clear_req = 1'b0; learn_valid = 1'b0;
        count_busy("clear_len", -1);
        for (int j = 0; j < 10; j++) begin
            k = 48'h050000000000 + 48'(j);
            lookup(k, oat(k));
        end
        lookup(48'h06060606060A, h);
        repeat (12) step();

        // Reset in the middle of a lookup stream.
        h = oat(48'h001122334455);
        learn(h[9:0], 48'h001122334455, 8'h09);
        for (int j = 0; j < 12; j++) begin
            if (j == 6 || j == 7) reset = 1'b1;
            else reset = 1'b0;
            key_valid = 1'b1; key = 48'h001122334455; req_hash = h;
            step();
        end
        key_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy("resweep_len", 300);
        repeat (12) step();

        check("sb_empty", 64'(sbq.size()), 64'd0);
        check("results_seen", 64'(n_results > 80), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
